// File: rtl/l2_mem_ctrl_pkg.sv
// rtl/l2_mem_ctrl_pkg.sv - message codes, widths and state encoding shared by the L2 memory controller
package l2_mem_ctrl_pkg;

  localparam int MSG_WIDTH      = 8;
  localparam int TAG_WIDTH      = 4;
  localparam int DATA_WIDTH     = 16;
  localparam int MEM_DEPTH      = 1 << TAG_WIDTH;
  localparam int MEM_CNT_WIDTH  = 4;
  localparam int MEM_STAT_WIDTH = 16;

  localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_MEM      = 8'd19;
  localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_MEM     = 8'd20;
  localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK  = 8'd21;
  localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_MEM_ACK = 8'd22;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE  = 2'd0,
    MEM_STATE_COUNT = 2'd1,
    MEM_STATE_ACK   = 2'd2
  } mem_state_e;

  function automatic logic is_mem_req(input logic [MSG_WIDTH-1:0] t);
    return (t == MSG_TYPE_LOAD_MEM) || (t == MSG_TYPE_STORE_MEM);
  endfunction

  function automatic logic [MSG_WIDTH-1:0] mem_ack_type(input logic [MSG_WIDTH-1:0] t);
    return (t == MSG_TYPE_LOAD_MEM) ? MSG_TYPE_LOAD_MEM_ACK : MSG_TYPE_STORE_MEM_ACK;
  endfunction

endpackage

// File: rtl/l2_mem_ctrl_if.sv
// rtl/l2_mem_ctrl_if.sv - L2 directory msg2 request / msg3 response channel pair
interface l2_mem_ctrl_if;
  import l2_mem_ctrl_pkg::*;

  logic [MSG_WIDTH-1:0]  req_type;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [DATA_WIDTH-1:0] req_data;
  logic [MSG_WIDTH-1:0]  rsp_type;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  busy;

  modport master (
    output req_type, req_tag, req_data,
    input  rsp_type, rsp_data, rsp_tag, busy
  );

  modport slave (
    input  req_type, req_tag, req_data,
    output rsp_type, rsp_data, rsp_tag, busy
  );

endinterface

// File: rtl/l2_mem_ctrl_mem_array.sv
// rtl/l2_mem_ctrl_mem_array.sv - tag-indexed backing store: one sync write port, one async read port, optional clear on reset
module l2_mem_ctrl_mem_array
  import l2_mem_ctrl_pkg::*;
#(
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [TAG_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [TAG_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  assign rdata_o = mem_q[raddr_i];

  always_ff @(posedge clk) begin
    if (rst && INIT_ZERO) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/l2_mem_ctrl.sv
// rtl/l2_mem_ctrl.sv - single-outstanding L2 memory controller with fixed ack latency
// Optional macro MEM_STATS_EN adds saturating load_cnt/store_cnt ack counters.
module l2_mem_ctrl
  import l2_mem_ctrl_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  l2_mem_ctrl_if.slave              bus
`ifdef MEM_STATS_EN
  ,
  output logic [MEM_STAT_WIDTH-1:0] load_cnt,
  output logic [MEM_STAT_WIDTH-1:0] store_cnt
`endif
);

  localparam logic [MEM_CNT_WIDTH-1:0] CNT_INIT = MEM_CNT_WIDTH'(LATENCY - 1);

  mem_state_e            state_q;
  logic [MEM_CNT_WIDTH-1:0] cnt_q;
  logic [MSG_WIDTH-1:0]  type_q, last_type_q, rsp_type_q;
  logic [TAG_WIDTH-1:0]  tag_q, last_tag_q, rsp_tag_q;
  logic [DATA_WIDTH-1:0] data_q, rsp_data_q, rd_data;
  logic                  armed_q, busy_q;
  logic                  req_is_mem, accept, mem_we;

  // req_type is level-held, so only a changed pair or a re-armed channel is a new request.
  assign req_is_mem = is_mem_req(bus.req_type);
  assign accept = (state_q == MEM_STATE_IDLE) && req_is_mem &&
                  (armed_q || (bus.req_type != last_type_q) || (bus.req_tag != last_tag_q));
  assign mem_we = (state_q == MEM_STATE_ACK) && (type_q == MSG_TYPE_STORE_MEM) && !rst;

  l2_mem_ctrl_mem_array #(
    .INIT_ZERO (INIT_ZERO)
  ) u_mem_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (tag_q),
    .wdata_i (data_q),
    .raddr_i (tag_q),
    .rdata_o (rd_data)
  );

  // The ACK state computes the response; it becomes visible on the edge leaving ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_STATE_IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      last_type_q <= '0;
      last_tag_q  <= '0;
      armed_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_type_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_type_q <= '0;
      rsp_tag_q  <= '0;
      rsp_data_q <= '0;
      case (state_q)
        MEM_STATE_IDLE: begin
          busy_q <= accept;
          if (!req_is_mem) begin
            armed_q <= 1'b1;
          end
          if (accept) begin
            armed_q     <= 1'b0;
            last_type_q <= bus.req_type;
            last_tag_q  <= bus.req_tag;
            type_q      <= bus.req_type;
            tag_q       <= bus.req_tag;
            data_q      <= bus.req_data;
            cnt_q       <= CNT_INIT;
            state_q     <= (LATENCY == 1) ? MEM_STATE_ACK : MEM_STATE_COUNT;
          end
        end
        MEM_STATE_COUNT: begin
          cnt_q <= cnt_q - MEM_CNT_WIDTH'(1);
          if (cnt_q == MEM_CNT_WIDTH'(1)) begin
            state_q <= MEM_STATE_ACK;
          end
        end
        MEM_STATE_ACK: begin
          rsp_type_q <= mem_ack_type(type_q);
          rsp_tag_q  <= tag_q;
          rsp_data_q <= (type_q == MSG_TYPE_LOAD_MEM) ? rd_data : '0;
          state_q    <= MEM_STATE_IDLE;
        end
        default: begin
          state_q <= MEM_STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_type = rsp_type_q;
  assign bus.rsp_tag  = rsp_tag_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.busy     = busy_q;

`ifdef MEM_STATS_EN
  logic [MEM_STAT_WIDTH-1:0] load_cnt_q, store_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (state_q == MEM_STATE_ACK) begin
      if (type_q == MSG_TYPE_LOAD_MEM) begin
        if (load_cnt_q != '1) load_cnt_q <= load_cnt_q + MEM_STAT_WIDTH'(1);
      end else begin
        if (store_cnt_q != '1) store_cnt_q <= store_cnt_q + MEM_STAT_WIDTH'(1);
      end
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// tb/tb_l2_mem_ctrl.sv - self-checking bench: timestamp reference model for LATENCY=4, directed LATENCY=1 instance
module tb_l2_mem_ctrl;
  import l2_mem_ctrl_pkg::*;

  localparam int LAT0 = 4;

  logic clk = 1'b0;
  logic rst, rst1;
  always #5 clk = ~clk;

  l2_mem_ctrl_if bus0 ();
  l2_mem_ctrl_if bus1 ();

`ifdef MEM_STATS_EN
  logic [15:0] lc0, sc0, lc1, sc1;
`endif

  l2_mem_ctrl #(.LATENCY(LAT0), .INIT_ZERO(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
`ifdef MEM_STATS_EN
    ,
    .load_cnt  (lc0),
    .store_cnt (sc0)
`endif
  );

  l2_mem_ctrl #(.LATENCY(1), .INIT_ZERO(1'b0)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
`ifdef MEM_STATS_EN
    ,
    .load_cnt  (lc1),
    .store_cnt (sc1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an accepted request at edge t acks at edge t+LAT0, channel idle again from t+LAT0+1.
  int cyc = 0;
  int free_at = 0;
  int ack_at = -1;
  bit armed = 1'b1;
  logic [7:0]  last_type = '0;
  logic [3:0]  last_tag = '0;
  logic [7:0]  p_type = '0;
  logic [3:0]  p_tag = '0;
  logic [15:0] p_data = '0;
  logic [15:0] mem_m [16];
  int m_loads = 0;
  int m_stores = 0;
  logic [7:0]  e_type;
  logic [3:0]  e_tag;
  logic [15:0] e_data;
  logic        e_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    cyc++;
    e_type = '0;
    e_tag  = '0;
    e_data = '0;
    if (rst) begin
      ack_at    = -1;
      free_at   = cyc;
      armed     = 1'b1;
      last_type = '0;
      last_tag  = '0;
      m_loads   = 0;
      m_stores  = 0;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
    end else begin
      if (cyc == ack_at) begin
        e_tag = p_tag;
        if (p_type == MSG_TYPE_LOAD_MEM) begin
          e_type = MSG_TYPE_LOAD_MEM_ACK;
          e_data = mem_m[p_tag];
          m_loads++;
        end else begin
          e_type = MSG_TYPE_STORE_MEM_ACK;
          mem_m[p_tag] = p_data;
          m_stores++;
        end
      end
      if (cyc >= free_at) begin
        if (bus0.req_type != MSG_TYPE_LOAD_MEM && bus0.req_type != MSG_TYPE_STORE_MEM) begin
          armed = 1'b1;
        end else if (armed || bus0.req_type != last_type || bus0.req_tag != last_tag) begin
          armed     = 1'b0;
          last_type = bus0.req_type;
          last_tag  = bus0.req_tag;
          p_type    = bus0.req_type;
          p_tag     = bus0.req_tag;
          p_data    = bus0.req_data;
          ack_at    = cyc + LAT0;
          free_at   = cyc + LAT0 + 1;
        end
      end
    end
    e_busy = (cyc < free_at);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rsp_type", 32'(bus0.rsp_type), 32'(e_type));
    check_eq("rsp_tag",  32'(bus0.rsp_tag),  32'(e_tag));
    check_eq("rsp_data", 32'(bus0.rsp_data), 32'(e_data));
    check_eq("busy",     32'(bus0.busy),     32'(e_busy));
  endtask

  task automatic drive0(input logic [7:0] t, input logic [3:0] tag, input logic [15:0] d, input int n);
    bus0.req_type = t;
    bus0.req_tag  = tag;
    bus0.req_data = d;
    repeat (n) tick();
  endtask

  // LATENCY=1 instance: accept on the first edge, ack visible after the next one, then quiet.
  task automatic d1_req(input logic [7:0] t, input logic [3:0] tag, input logic [15:0] d,
                        input logic [15:0] exp_data);
    bus1.req_type = t;
    bus1.req_tag  = tag;
    bus1.req_data = d;
    tick();
    check_eq("d1_busy_accept", 32'(bus1.busy), 32'd1);
    check_eq("d1_rsp_early",   32'(bus1.rsp_type), 32'd0);
    bus1.req_type = '0;
    tick();
    check_eq("d1_ack_type", 32'(bus1.rsp_type),
             (t == MSG_TYPE_LOAD_MEM) ? 32'(MSG_TYPE_LOAD_MEM_ACK) : 32'(MSG_TYPE_STORE_MEM_ACK));
    check_eq("d1_ack_tag",  32'(bus1.rsp_tag), 32'(tag));
    check_eq("d1_ack_data", 32'(bus1.rsp_data), 32'(exp_data));
    check_eq("d1_busy_ack", 32'(bus1.busy), 32'd1);
    tick();
    check_eq("d1_rsp_after", 32'(bus1.rsp_type), 32'd0);
    check_eq("d1_busy_after", 32'(bus1.busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rst1 = 1'b1;
    bus0.req_type = '0; bus0.req_tag = '0; bus0.req_data = '0;
    bus1.req_type = '0; bus1.req_tag = '0; bus1.req_data = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    rst1 = 1'b0;

    drive0(MSG_TYPE_LOAD_MEM, 4'd3, 16'h0, 8);
    drive0(8'h00, 4'd0, 16'h0, 2);

    drive0(MSG_TYPE_STORE_MEM, 4'd5, 16'h00A5, 7);
    drive0(MSG_TYPE_LOAD_MEM, 4'd5, 16'h0, 7);
    drive0(8'h00, 4'd0, 16'h0, 2);

    drive0(MSG_TYPE_LOAD_MEM, 4'd2, 16'h0, 20);
    drive0(8'h00, 4'd0, 16'h0, 1);
    drive0(MSG_TYPE_LOAD_MEM, 4'd2, 16'h0, 8);

    drive0(MSG_TYPE_STORE_MEM, 4'd1, 16'h5A5A, 2);
    drive0(MSG_TYPE_LOAD_MEM, 4'd6, 16'h0, 10);
    drive0(8'h00, 4'd0, 16'h0, 2);

    drive0(MSG_TYPE_STORE_MEM, 4'd4, 16'h003C, 2);
    bus0.req_type = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(8'h00, 4'd0, 16'h0, 1);
    drive0(MSG_TYPE_LOAD_MEM, 4'd4, 16'h0, 7);
    drive0(8'h00, 4'd0, 16'h0, 2);

    // Contents written before a reset must survive it when INIT_ZERO=0.
    d1_req(MSG_TYPE_STORE_MEM, 4'd7, 16'h0077, 16'h0);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    tick();
    d1_req(MSG_TYPE_STORE_MEM, 4'd1, 16'h1111, 16'h0);
    d1_req(MSG_TYPE_STORE_MEM, 4'd2, 16'h2222, 16'h0);
    d1_req(MSG_TYPE_LOAD_MEM,  4'd7, 16'h0, 16'h0077);
    d1_req(MSG_TYPE_LOAD_MEM,  4'd1, 16'h0, 16'h1111);
    d1_req(MSG_TYPE_LOAD_MEM,  4'd2, 16'h0, 16'h2222);
`ifdef MEM_STATS_EN
    check_eq("d1_load_cnt",  32'(lc1), 32'd3);
    check_eq("d1_store_cnt", 32'(sc1), 32'd2);
`endif

    for (int k = 0; k < 400; k++) begin
      int kind;
      logic [7:0] t;
      kind = int'($urandom_range(0, 9));
      if (kind <= 3)      t = MSG_TYPE_LOAD_MEM;
      else if (kind <= 6) t = MSG_TYPE_STORE_MEM;
      else if (kind <= 8) t = 8'h00;
      else                t = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      drive0(t, 4'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(1, 8)));
    end
    drive0(8'h00, 4'd0, 16'h0, 8);
`ifdef MEM_STATS_EN
    check_eq("d0_load_cnt",  32'(lc0), 32'(m_loads));
    check_eq("d0_store_cnt", 32'(sc0), 32'(m_stores));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
